// File: rtl/ddr_wr_burst.sv
`default_nettype none
// ============================================================================
// Module      : ddr_wr_burst
// Description : Write-burst staging FIFO between the Wishbone write buffer and
//               the DDR command/PHY layer. Collects 4-beat write bursts, then
//               replays each one as a DDR write command followed by 4
//               PHY-paced data beats with DDR data-mask bits.
// Options     : DDR_WR_SKIP_EMPTY_EN - drop bursts whose 16 byte-valid bits
//               are all zero instead of forwarding them.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_wr_burst #(
  parameter int DEPTH_LOG2 = 1
) (
  input  logic        clk,
  input  logic        reset,
  // upstream burst input
  input  logic        i_wr_req,
  input  logic [27:0] i_wr_adr,
  input  logic [31:0] i_wr_dat,
  input  logic [3:0]  i_wr_val,
  output logic        o_wr_ack,
  // DDR command side
  output logic        o_ddr_cmd_req,
  output logic [27:0] o_ddr_cmd_adr,
  input  logic        i_ddr_cmd_ack,
  // PHY write-data side
  input  logic        i_ddr_wd_rd,
  output logic [31:0] o_ddr_wd_dat,
  output logic [3:0]  o_ddr_wd_mask,
  output logic        o_busy
);

  localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);

  // Burst storage, one beat per packed element.
  logic [3:0][31:0] r_mem_dat [c_DEPTH];
  logic [3:0][3:0]  r_mem_val [c_DEPTH];
  logic [27:0]      r_mem_adr [c_DEPTH];

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [DEPTH_LOG2:0] r_tail;
  logic [DEPTH_LOG2:0] r_cmd;
  logic [DEPTH_LOG2:0] r_head;
  logic [DEPTH_LOG2:0] r_count;
  logic                r_full;
  logic [1:0]          r_in_beat;
  logic [1:0]          r_out_beat;

  logic [DEPTH_LOG2-1:0] w_tail_idx;
  logic [DEPTH_LOG2-1:0] w_cmd_idx;
  logic [DEPTH_LOG2-1:0] w_head_idx;
  logic                  w_in_fire;
  logic                  w_last_in;
  logic                  w_commit;
  logic                  w_cmd_fire;
  logic                  w_data_rdy;
  logic                  w_rd_fire;
  logic                  w_free;
  logic [DEPTH_LOG2:0]   w_count_nxt;

  assign w_tail_idx = r_tail[DEPTH_LOG2-1:0];
  assign w_cmd_idx  = r_cmd[DEPTH_LOG2-1:0];
  assign w_head_idx = r_head[DEPTH_LOG2-1:0];

  // Input side: full only ever blocks at a burst start, because count moves
  // up only when a whole burst commits.
  assign o_wr_ack  = i_wr_req && !r_full;
  assign w_in_fire = o_wr_ack;
  assign w_last_in = w_in_fire && (r_in_beat == 2'd3);

`ifdef DDR_WR_SKIP_EMPTY_EN
  // Beats 0..2 are already stored; beat 3 is still on the input port.
  logic w_empty_burst;
  assign w_empty_burst = (r_mem_val[w_tail_idx][2:0] == '0) && (i_wr_val == 4'h0);
  assign w_commit      = w_last_in && !w_empty_burst;
`else
  assign w_commit      = w_last_in;
`endif

  // Command side: every committed entry not yet announced gets a command.
  assign o_ddr_cmd_req = (r_cmd != r_tail);
  assign o_ddr_cmd_adr = r_mem_adr[w_cmd_idx];
  assign w_cmd_fire    = o_ddr_cmd_req && i_ddr_cmd_ack;

  // Data side: the head entry may stream only once its command was accepted.
  assign w_data_rdy    = (r_head != r_cmd);
  assign w_rd_fire     = w_data_rdy && i_ddr_wd_rd;
  assign w_free        = w_rd_fire && (r_out_beat == 2'd3);

  assign o_ddr_wd_dat  = w_data_rdy ? r_mem_dat[w_head_idx][r_out_beat] : 32'h0;
  assign o_ddr_wd_mask = w_data_rdy ? ~r_mem_val[w_head_idx][r_out_beat] : 4'hF;

  assign o_busy        = (r_count != '0) || (r_in_beat != 2'd0);

  // Next occupancy: a commit and a free in the same cycle cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_commit && !w_free) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_commit && w_free) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Pointer, beat counter and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tail     <= '0;
      r_cmd      <= '0;
      r_head     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_in_beat  <= 2'd0;
      r_out_beat <= 2'd0;
    end else begin
      if (w_in_fire) begin
        r_in_beat <= r_in_beat + 2'd1;
      end
      if (w_commit) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_cmd_fire) begin
        r_cmd <= r_cmd + 1'b1;
      end
      if (w_rd_fire) begin
        r_out_beat <= r_out_beat + 2'd1;
      end
      if (w_free) begin
        r_head <= r_head + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_DEPTH_CNT);
    end
  end

  // Beat capture into the tail slot; a partial burst lives there until commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem_dat[i] <= '0;
        r_mem_val[i] <= '0;
        r_mem_adr[i] <= '0;
      end
    end else if (w_in_fire) begin
      r_mem_dat[w_tail_idx][r_in_beat] <= i_wr_dat;
      r_mem_val[w_tail_idx][r_in_beat] <= i_wr_val;
      if (r_in_beat == 2'd0) begin
        r_mem_adr[w_tail_idx] <= i_wr_adr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_wr_burst
// Description : Scoreboard bench for ddr_wr_burst. The stimulus thread pushes
//               every committed burst into an expected-command queue; a
//               monitor moves entries to an expected-data queue on command
//               accept and compares every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_wr_burst;

  localparam int DEPTH_LOG2 = 1;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef DDR_WR_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [27:0]      adr;
    logic [3:0][31:0] dat;
    logic [3:0][3:0]  val;
  } burst_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_wr_req = 1'b0;
  logic [27:0] i_wr_adr = '0;
  logic [31:0] i_wr_dat = '0;
  logic [3:0]  i_wr_val = '0;
  logic        o_wr_ack;
  logic        o_ddr_cmd_req;
  logic [27:0] o_ddr_cmd_adr;
  logic        i_ddr_cmd_ack = 1'b0;
  logic        i_ddr_wd_rd = 1'b0;
  logic [31:0] o_ddr_wd_dat;
  logic [3:0]  o_ddr_wd_mask;
  logic        o_busy;

  ddr_wr_burst #(.DEPTH_LOG2(DEPTH_LOG2)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .i_wr_req      (i_wr_req),
    .i_wr_adr      (i_wr_adr),
    .i_wr_dat      (i_wr_dat),
    .i_wr_val      (i_wr_val),
    .o_wr_ack      (o_wr_ack),
    .o_ddr_cmd_req (o_ddr_cmd_req),
    .o_ddr_cmd_adr (o_ddr_cmd_adr),
    .i_ddr_cmd_ack (i_ddr_cmd_ack),
    .i_ddr_wd_rd   (i_ddr_wd_rd),
    .o_ddr_wd_dat  (o_ddr_wd_dat),
    .o_ddr_wd_mask (o_ddr_wd_mask),
    .o_busy        (o_busy)
  );

  initial forever #5 clk = ~clk;

  // Reference model state: bursts awaiting a command, bursts awaiting data.
  burst_t cmd_q[$];
  burst_t data_q[$];
  int     out_beat_m = 0;
  int     in_beats   = 0;
  int     p_cmd      = 0;
  int     p_rd       = 0;
  int     cyc        = 0;
  int     n_checks   = 0;
  int     n_fail     = 0;
  bit     abort      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit dropped(input burst_t b);
    return SKIP && (b.val == '0);
  endfunction

  function automatic burst_t rand_burst();
    burst_t b;
    b.adr = 28'($urandom);
    for (int k = 0; k < 4; k++) begin
      b.dat[k] = $urandom;
      b.val[k] = 4'($urandom);
    end
    if ($urandom_range(7) == 0) b.val = '0;
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream PHY/command model with adjustable acceptance rates.
  initial forever begin
    @(posedge clk);
    #1;
    i_ddr_cmd_ack = ($urandom_range(99) < p_cmd);
    i_ddr_wd_rd   = ($urandom_range(99) < p_rd);
  end

  // Monitor: compare on the falling edge, advance the model on the rising edge.
  initial begin
    bit         acc_cmd;
    bit         acc_rd;
    burst_t     f;
    logic [3:0] m;
    int         occ;
    forever begin
      @(negedge clk);
      acc_cmd = 1'b0;
      acc_rd  = 1'b0;
      if (!reset) begin
        occ = cmd_q.size() + data_q.size();
        chk("wr_ack", o_wr_ack, i_wr_req && (occ < DEPTH));
        chk("cmd_req", o_ddr_cmd_req, cmd_q.size() != 0);
        if (cmd_q.size() != 0) chk("cmd_adr", o_ddr_cmd_adr, cmd_q[0].adr);
        if (data_q.size() != 0) begin
          f = data_q[0];
          m = ~f.val[out_beat_m];
          chk("wd_dat", o_ddr_wd_dat, f.dat[out_beat_m]);
          chk("wd_mask", o_ddr_wd_mask, m);
        end else begin
          chk("idle_dat", o_ddr_wd_dat, 32'h0);
          chk("idle_mask", o_ddr_wd_mask, 4'hF);
        end
        chk("busy", o_busy, (occ != 0) || (in_beats != 0));
        acc_cmd = (cmd_q.size() != 0) && i_ddr_cmd_ack;
        acc_rd  = (data_q.size() != 0) && i_ddr_wd_rd;
      end
      @(posedge clk);
      if (!reset) begin
        if (acc_rd) begin
          out_beat_m++;
          if (out_beat_m == 4) begin
            void'(data_q.pop_front());
            out_beat_m = 0;
          end
        end
        if (acc_cmd) data_q.push_back(cmd_q.pop_front());
      end
    end
  end

  // Present nbeats beats of a burst; each waits (bounded) for its ack.
  task automatic send_burst(input burst_t b, input int nbeats);
    int waited;
    bit got;
    for (int k = 0; k < nbeats; k++) begin
      if (abort) break;
      i_wr_req = 1'b1;
      i_wr_adr = b.adr;
      i_wr_dat = b.dat[k];
      i_wr_val = b.val[k];
      waited   = 0;
      got      = 1'b0;
      while (!got && !abort) begin
        @(negedge clk);
        got = o_wr_ack;
        if (!got) begin
          waited++;
          if (waited > 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_ack_timeout at %0t: no ack after %0d cycles", $time, waited);
            abort = 1'b1;
          end
        end
      end
      if (abort) break;
      @(posedge clk);
      in_beats = (in_beats + 1) % 4;
      if (k == 3 && !dropped(b)) cmd_q.push_back(b);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n     = 0;
    p_cmd = 100;
    p_rd  = 100;
    while ((cmd_q.size() + data_q.size()) != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout at %0t: %0d entries left", $time, cmd_q.size() + data_q.size());
      abort = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    chk({tag, "_wr_ack"},  o_wr_ack, 1'b0);
    chk({tag, "_cmd_req"}, o_ddr_cmd_req, 1'b0);
    chk({tag, "_cmd_adr"}, o_ddr_cmd_adr, 28'h0);
    chk({tag, "_wd_dat"},  o_ddr_wd_dat, 32'h0);
    chk({tag, "_wd_mask"}, o_ddr_wd_mask, 4'hF);
    chk({tag, "_busy"},    o_busy, 1'b0);
  endtask

  initial begin
    burst_t b;
    int     t0;
    int     gap;
    int     lvls[3] = '{100, 50, 20};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single burst with full byte-valid; command must be pending next cycle
    p_cmd = 0;
    p_rd  = 0;
    b.adr = 28'h0000123;
    b.dat = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    b.val = {4'hF, 4'hF, 4'hF, 4'hF};
    send_burst(b, 4);
    i_wr_req = 1'b0;
    @(negedge clk);
    chk("lat_cmd_req", o_ddr_cmd_req, 1'b1);
    chk("lat_cmd_adr", o_ddr_cmd_adr, 28'h0000123);
    drain();

    // Partial byte-valid pattern
    b     = rand_burst();
    b.val = {4'b1000, 4'hF, 4'h0, 4'b0011};
    send_burst(b, 4);
    i_wr_req = 1'b0;
    drain();

    // Full: two bursts back-to-back in 8 cycles, third blocked until drained
    p_cmd = 0;
    p_rd  = 0;
    t0    = cyc;
    send_burst(rand_burst(), 4);
    send_burst(rand_burst(), 4);
    chk("two_bursts_cycles", cyc - t0, 8);
    fork
      send_burst(rand_burst(), 4);
      begin
        repeat (10) @(negedge clk);
        chk("full_no_ack", o_wr_ack, 1'b0);
        chk("full_busy", o_busy, 1'b1);
        @(posedge clk);
        #1;
        p_cmd = 100;
        p_rd  = 100;
      end
    join
    i_wr_req = 1'b0;
    drain();

    // Fully masked burst: dropped or forwarded depending on the build option
    b     = rand_burst();
    b.val = '0;
    send_burst(b, 4);
    i_wr_req = 1'b0;
    drain();

    // Reset in the middle of a burst with a committed entry still queued
    p_cmd = 0;
    p_rd  = 0;
    send_burst(rand_burst(), 4);
    send_burst(rand_burst(), 2);
    reset    = 1'b1;
    i_wr_req = 1'b0;
    cmd_q.delete();
    data_q.delete();
    out_beat_m = 0;
    in_beats   = 0;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_burst(rand_burst(), 4);
    i_wr_req = 1'b0;
    drain();

    // Randomized traffic with varying downstream back-pressure
    for (int i = 0; i < 200 && !abort; i++) begin
      if (i % 20 == 0) begin
        p_cmd = lvls[$urandom_range(2)];
        p_rd  = lvls[$urandom_range(2)];
      end
      send_burst(rand_burst(), 4);
      gap = $urandom_range(2);
      if (gap != 0) begin
        i_wr_req = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    i_wr_req = 1'b0;
    if (!abort) drain();
    @(negedge clk);
    chk("end_busy", o_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_wr_burst.md
# ddr_wr_burst

Write-burst staging stage between the Wishbone write buffer and the DDR command/PHY layer. It accepts 4-beat write bursts (32-bit data plus 4-bit byte-valid per beat, 128-bit line address `[31:4]`) over the `wr_req`/`wr_ack` handshake produced by the Wishbone DDR front end. It stores them in a small burst FIFO and replays each burst downstream as one DDR write command followed by 4 PHY-paced data beats carrying DDR data-mask bits.

## Interface
- `DEPTH_LOG2`, default 1: log2 of burst FIFO entries (default 2 entries of 128 data + 16 valid + 28 address bits).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `wr_req` in 1: upstream burst request; held high for all 4 beats.
- `wr_adr` in 28: line address `[31:4]`; stable while `wr_req` is high.
- `wr_dat` in 32: current beat data.
- `wr_val` in 4: current beat byte-valid, 1 = byte written.
- `wr_ack` out 1: beat accepted this cycle.
- `ddr_cmd_req` out 1: write command pending.
- `ddr_cmd_adr` out 28: line address of pending command.
- `ddr_cmd_ack` in 1: command accepted this cycle.
- `ddr_wd_rd` in 1: PHY consumes one data beat this cycle.
- `ddr_wd_dat` out 32: current outgoing beat data.
- `ddr_wd_mask` out 4: DDR DM, 1 = byte masked; equals `~wr_val` of that beat.
- `busy` out 1: FIFO non-empty or input burst partially collected.

## Operation
- **Input side:** `wr_ack = wr_req & ~full`. The input beat counter `in_beat[1:0]` increments on each ack.
  - Beat n goes to slice `[32n+31:32n]` of the tail entry.
  - `wr_adr` is captured on beat 0.
  - On the 4th ack, the entry commits: tail pointer +1, count +1.
- **Full:** count == 2^DEPTH_LOG2. While full, no acks, including mid-burst, since `full` is evaluated per cycle. A partially collected entry occupies the tail slot and is not counted until commit. Full therefore only blocks at the start of a new burst once count reaches depth.
- **Command side:** `ddr_cmd_req = (cmd_ptr != tail_ptr)`, and `ddr_cmd_adr` = address at `cmd_ptr`. On `ddr_cmd_req & ddr_cmd_ack`, `cmd_ptr` +1. Commands may run ahead of data by any number of committed entries.
- **Data side:** entry at `head_ptr` is data-ready when `head_ptr != cmd_ptr`, i.e. its command has been accepted.
  - Outputs come from the head entry slice selected by `out_beat`.
  - On `ddr_wd_rd` while data-ready, `out_beat` +1.
  - On the 4th beat the entry frees: head +1, count −1.
- **Idle outputs:** when not data-ready, `ddr_wd_dat = 0` and `ddr_wd_mask = 4'hF`. `ddr_wd_rd` is ignored (no state change).
- **Simultaneous events:** commit and free in the same cycle leave count unchanged. Commit and command-accept in the same cycle are both honoured. A command for an entry cannot be accepted in its commit cycle; `ddr_cmd_req` rises the cycle after commit.
- **Pointers** wrap modulo 2^DEPTH_LOG2, with an extra MSB to distinguish full from empty.

## Timing
- **Reset values:** `wr_ack` = 0 (with `wr_req` low); `ddr_cmd_req` 0; `ddr_cmd_adr` 0; `ddr_wd_dat` 0; `ddr_wd_mask` 4'hF; `busy` 0. All pointers, counters and `in_beat`/`out_beat` are 0.
- **Latency:** 4th input ack at cycle T → `ddr_cmd_req` high at T+1. Command ack at cycle C → data-ready from C+1.
- `wr_ack` is combinational from `wr_req` and registered `full`. Every other output is registered state or a mux of registered state.
- **Reset mid-operation:** all entries, including any partial burst, are discarded immediately. Upstream must also be in reset.

## Configuration
- **With `DDR_WR_SKIP_EMPTY_EN` defined:** at commit, if all 16 valid bits of the burst are 0, the entry is dropped. The tail pointer does not advance, no command is issued, and `wr_ack` behaviour is unchanged.
- **Without it:** every burst is forwarded, even fully masked (`ddr_wd_mask = 4'hF` on all 4 beats).

## Test plan
- **Single burst:** addr 28'h0000123, data 0x11111111..0x44444444, val 4'hF each → `ddr_cmd_req` rises 1 cycle after the 4th ack with adr 28'h0000123. After `ddr_cmd_ack`, 4 `ddr_wd_rd` return data in order with mask 4'h0.
- **Partial mask:** val 4'b0011, 4'h0, 4'hF, 4'b1000 → masks 4'b1100, 4'hF, 4'h0, 4'b0111.
- **Full:** 3 back-to-back bursts with `ddr_cmd_ack` held low (DEPTH_LOG2=1) → bursts 1–2 acked in 8 cycles, `wr_ack` stays 0 for burst 3. One cmd ack plus 4 rd frees an entry, then burst 3 is acked.
- **Concurrency:** burst commits in the same cycle the last `ddr_wd_rd` frees the previous entry → count stays 1, no data corruption, and the next command issues.
- **Reset mid-burst:** assert `reset` after 2 acks → all outputs at reset values, `busy` = 0. A new burst after reset completes correctly.
- **Skip-empty:** burst with val 4'h0 ×4 → with `DDR_WR_SKIP_EMPTY_EN` defined, no `ddr_cmd_req` and `busy` = 0 after the 4th ack. Without it, a command is issued and all masks are 4'hF.
